// File: rtl/nonce_dispatch_pkg.sv
// nonce_dispatch_pkg: shared FSM state type, nonce width and beat-count helper
package nonce_dispatch_pkg;
   typedef enum logic {IDLE, ISSUE} dispatch_state_t;
   localparam int NONCE_W = 32;
   function automatic longint beats(input longint cnt, input longint cores);
      return (cnt + cores - 1) / cores;
   endfunction
endpackage

// File: rtl/nonce_lane_mask.sv
// nonce_lane_mask: per-core enable for a beat, lanes at or past BROADCAST_CNT are off
module nonce_lane_mask
   import nonce_dispatch_pkg::*;
#(
   parameter int     NUM_CORES     = 10,
   parameter longint BROADCAST_CNT = 100
) (
   input  logic [NONCE_W-1:0]   nonce_base_i,
   output logic [NUM_CORES-1:0] lanes_o
);
   localparam logic [NONCE_W:0] LIMIT = (NONCE_W+1)'(BROADCAST_CNT);
   // one extra bit so base + k near 2^32 cannot wrap into an enabled lane
   for (genvar k = 0; k < NUM_CORES; k++) begin : g_lane
      assign lanes_o[k] = ({1'b0, nonce_base_i} + (NONCE_W+1)'(k)) < LIMIT;
   end
endmodule

// File: rtl/nonce_dispatcher.sv
// nonce_dispatcher: accepts one header per session and broadcasts it as nonce-stride beats,
// ending on the last beat or early on abort_i.
module nonce_dispatcher
   import nonce_dispatch_pkg::*;
#(
   parameter int     NUM_CORES     = 10,
   parameter longint BROADCAST_CNT = 100
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 block_valid_i,
   output logic                 block_ready_o,
   input  logic [255:0]         header_i,
   input  logic                 stall_i,
   input  logic                 abort_i,
   output logic                 valid_o,
   output logic                 newblock_o,
   output logic                 last_o,
   output logic [NONCE_W-1:0]   nonce_base_o,
   output logic [NUM_CORES-1:0] lanes_o,
   output logic [255:0]         header_o,
   output logic                 done_o,
   output logic                 aborted_o
);
   localparam longint BEATS = beats(BROADCAST_CNT, NUM_CORES);
   localparam logic [NONCE_W-1:0] LAST_BASE = NONCE_W'((BEATS - 1) * NUM_CORES);
   if (BROADCAST_CNT < 1 || BROADCAST_CNT > 64'sd4294967296 || NUM_CORES < 1) begin : g_bad_cfg
      $error("nonce_dispatcher: BROADCAST_CNT must be 1..2^32 and NUM_CORES >= 1");
   end
   dispatch_state_t      state_q, state_d;
   logic [NONCE_W-1:0]   base_q, base_d;
   logic [255:0]         header_q, header_d;
   logic                 done_q, done_d, aborted_q, aborted_d;
   logic                 issue, accept, consume, last, ending;
   logic [NUM_CORES-1:0] mask;
   nonce_lane_mask #(
      .NUM_CORES    (NUM_CORES),
      .BROADCAST_CNT(BROADCAST_CNT)
   ) u_mask (
      .nonce_base_i(base_q),
      .lanes_o     (mask)
   );
   always_comb begin
      issue     = state_q == ISSUE;
      accept    = !issue & block_valid_i;
      consume   = issue & !stall_i;
      last      = base_q == LAST_BASE;
      // abort wins over advancing, whether or not the beat was taken
      ending    = issue & (abort_i | (consume & last));
      state_d   = accept ? ISSUE : ending ? IDLE : state_q;
      base_d    = accept ? '0 : consume ? base_q + NONCE_W'(NUM_CORES) : base_q;
      header_d  = accept ? header_i : header_q;
      done_d    = ending;
      aborted_d = issue & abort_i;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         base_q    <= '0;
         header_q  <= '0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         header_q  <= header_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end
   assign block_ready_o = !issue;
   assign valid_o       = issue;
   assign newblock_o    = issue & (base_q == '0);
   assign last_o        = issue & last;
   assign nonce_base_o  = issue ? base_q : '0;
   assign lanes_o       = issue ? mask : '0;
   assign header_o      = header_q;
   assign done_o        = done_q;
   assign aborted_o     = aborted_q;
endmodule

// File: tb/tb_nonce_dispatcher.sv
// tb_nonce_dispatcher: table vectors on a 10/25 instance, directed and random sessions
// on a 10/100 instance against an integer-level session model.
module tb_nonce_dispatcher;
   localparam int NC  = 10;
   localparam int CNT = 100;
   localparam int BTS = (CNT + NC - 1) / NC;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic         block_valid_i = 0, stall_i = 0, abort_i = 0;
   logic [255:0] header_i = '0;
   logic         block_ready_o, valid_o, newblock_o, last_o, done_o, aborted_o;
   logic [31:0]  nonce_base_o;
   logic [9:0]   lanes_o;
   logic [255:0] header_o;
   logic         t_bv = 0, t_st = 0, t_ab = 0;
   logic [255:0] t_hdr = '0;
   logic         t_ready, t_valid, t_nb, t_last, t_done, t_abd;
   logic [31:0]  t_base;
   logic [9:0]   t_lanes;
   logic [255:0] t_hout;
   nonce_dispatcher #(.NUM_CORES(NC), .BROADCAST_CNT(CNT)) dut (
      .clk(clk), .rst(rst), .block_valid_i(block_valid_i), .block_ready_o(block_ready_o),
      .header_i(header_i), .stall_i(stall_i), .abort_i(abort_i), .valid_o(valid_o),
      .newblock_o(newblock_o), .last_o(last_o), .nonce_base_o(nonce_base_o),
      .lanes_o(lanes_o), .header_o(header_o), .done_o(done_o), .aborted_o(aborted_o));
   nonce_dispatcher #(.NUM_CORES(10), .BROADCAST_CNT(25)) dut25 (
      .clk(clk), .rst(rst), .block_valid_i(t_bv), .block_ready_o(t_ready),
      .header_i(t_hdr), .stall_i(t_st), .abort_i(t_ab), .valid_o(t_valid),
      .newblock_o(t_nb), .last_o(t_last), .nonce_base_o(t_base),
      .lanes_o(t_lanes), .header_o(t_hout), .done_o(t_done), .aborted_o(t_abd));
   int n_cmp = 0, n_bad = 0;
   task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask
   // session model: active flag, beat index, header, pending done pulse
   bit           m_act = 0, m_done = 0, m_ab = 0;
   int           m_idx = 0;
   logic [255:0] m_hdr = '0;
   function automatic logic [9:0] exp_lanes(input int idx);
      logic [9:0] l;
      for (int k = 0; k < NC; k++) l[k] = (longint'(idx) * NC + k) < CNT;
      return l;
   endfunction
   task automatic step(input bit bv, input logic [255:0] h, input bit st, input bit ab);
      m_done = 0;
      m_ab   = 0;
      if (!m_act) begin
         if (bv) begin m_act = 1; m_idx = 0; m_hdr = h; end
      end else if (ab) begin
         m_act = 0; m_done = 1; m_ab = 1;
      end else if (!st) begin
         if (m_idx == BTS - 1) begin m_act = 0; m_done = 1; end
         else m_idx++;
      end
   endtask
   task automatic check_dut();
      chk("ready", block_ready_o, !m_act);
      chk("valid", valid_o, m_act);
      chk("newblock", newblock_o, m_act && m_idx == 0);
      chk("last", last_o, m_act && m_idx == BTS - 1);
      chk("base", nonce_base_o, m_act ? m_idx * NC : 0);
      chk("lanes", lanes_o, m_act ? exp_lanes(m_idx) : 10'h0);
      chk("header", header_o, m_hdr);
      chk("done", done_o, m_done);
      chk("aborted", aborted_o, m_ab);
   endtask
   int           cyc_no = 0, beat_cnt, last_cyc, done_cyc, gap, nb_cnt, base30_cnt;
   bit           done_seen, done_ab, done_rdy, seen40;
   logic [255:0] nb_hdr;
   task automatic clear();
      beat_cnt = 0; last_cyc = 0; done_cyc = 0; gap = 0; nb_cnt = 0; base30_cnt = 0;
      done_seen = 0; done_ab = 0; done_rdy = 0; seen40 = 0; nb_hdr = '0;
   endtask
   task automatic cyc(input bit bv, input logic [255:0] h, input bit st, input bit ab);
      @(negedge clk);
      block_valid_i = bv; header_i = h; stall_i = st; abort_i = ab;
      @(posedge clk);
      step(bv, h, st, ab);
      #1;
      check_dut();
      cyc_no++;
      if (valid_o) begin
         beat_cnt++;
         if (last_o) last_cyc = cyc_no;
         if (nonce_base_o == 30) base30_cnt++;
         if (nonce_base_o == 40) seen40 = 1;
         if (newblock_o) begin nb_cnt++; gap = cyc_no - last_cyc; nb_hdr = header_o; end
      end
      if (done_o) begin done_seen = 1; done_cyc = cyc_no; done_ab = aborted_o; done_rdy = block_ready_o; end
   endtask
   typedef struct {
      bit bv, st, ab;
      bit valid, nb, last, done, abd;
      int unsigned base;
      logic [9:0] lanes;
   } vec_t;
   vec_t tbl[10];
   logic [255:0] hA = {8{32'hA5A5_0001}}, hB = {8{32'h5A5A_0002}};
   logic [255:0] hC = {8{32'h1234_0003}}, hD = {8{32'hCAFE_0004}};
   bit st, ab;
   int sl;
   initial begin
      tbl[0] = '{1, 0, 0, 1, 1, 0, 0, 0, 0,  10'h3ff};
      tbl[1] = '{0, 0, 0, 1, 0, 0, 0, 0, 10, 10'h3ff};
      tbl[2] = '{0, 1, 0, 1, 0, 0, 0, 0, 10, 10'h3ff};
      tbl[3] = '{0, 0, 0, 1, 0, 1, 0, 0, 20, 10'h01f};
      tbl[4] = '{0, 0, 0, 0, 0, 0, 1, 0, 0,  10'h000};
      tbl[5] = '{1, 0, 0, 1, 1, 0, 0, 0, 0,  10'h3ff};
      tbl[6] = '{0, 1, 1, 0, 0, 0, 1, 1, 0,  10'h000};
      tbl[7] = '{0, 0, 1, 0, 0, 0, 0, 0, 0,  10'h000};
      tbl[8] = '{1, 0, 0, 1, 1, 0, 0, 0, 0,  10'h3ff};
      tbl[9] = '{0, 0, 1, 0, 0, 0, 1, 1, 0,  10'h000};
      repeat (2) @(posedge clk);
      #1;
      check_dut();
      chk("t_reset_ready", t_ready, 1);
      chk("t_reset_valid", t_valid, 0);
      @(negedge clk) rst = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         t_bv = tbl[i].bv; t_st = tbl[i].st; t_ab = tbl[i].ab; t_hdr = {8{$urandom}};
         @(posedge clk);
         #1;
         chk($sformatf("t%0d_valid", i), t_valid, tbl[i].valid);
         chk($sformatf("t%0d_nb", i), t_nb, tbl[i].nb);
         chk($sformatf("t%0d_last", i), t_last, tbl[i].last);
         chk($sformatf("t%0d_base", i), t_base, tbl[i].base);
         chk($sformatf("t%0d_lanes", i), t_lanes, tbl[i].lanes);
         chk($sformatf("t%0d_done", i), t_done, tbl[i].done);
         chk($sformatf("t%0d_aborted", i), t_abd, tbl[i].abd);
      end
      @(negedge clk) begin t_bv = 0; t_st = 0; t_ab = 0; end
      clear();
      cyc(1, hA, 0, 0);
      for (int i = 0; i < 20 && !done_seen; i++) cyc(0, '0, 0, 0);
      chk("plain_done_seen", done_seen, 1);
      chk("plain_beats", beat_cnt, 10);
      chk("plain_done_lat", done_cyc - last_cyc, 1);
      chk("plain_aborted", done_ab, 0);
      clear();
      sl = 3;
      cyc(1, hB, 0, 0);
      for (int i = 0; i < 30 && !done_seen; i++) begin
         st = valid_o && nonce_base_o == 30 && sl > 0;
         if (st) sl--;
         cyc(0, '0, st, 0);
      end
      chk("stall_done_seen", done_seen, 1);
      chk("stall_beats", beat_cnt, 13);
      chk("stall_hold30", base30_cnt, 4);
      clear();
      cyc(1, hC, 0, 0);
      for (int i = 0; i < 20 && !done_seen; i++) begin
         ab = valid_o && nonce_base_o == 30;
         cyc(0, '0, 0, ab);
      end
      chk("abort_done_seen", done_seen, 1);
      chk("abort_aborted", done_ab, 1);
      chk("abort_ready", done_rdy, 1);
      chk("abort_no40", seen40, 0);
      chk("abort_beats", beat_cnt, 4);
      clear();
      cyc(1, hA, 0, 0);
      for (int i = 0; i < 40 && nb_cnt < 2; i++) cyc(1, hB, 0, 0);
      chk("b2b_second", nb_cnt, 2);
      chk("b2b_gap", gap, 2);
      chk("b2b_header", nb_hdr, hB);
      done_seen = 0;
      for (int i = 0; i < 20 && !done_seen; i++) cyc(0, '0, 0, 0);
      chk("b2b_done2", done_seen, 1);
      clear();
      cyc(1, hC, 0, 0);
      for (int i = 0; i < 20 && !(valid_o && nonce_base_o == 50); i++) cyc(0, '0, 0, 0);
      chk("rst_reach50", nonce_base_o, 50);
      #2 rst = 1;
      #1;
      chk("rst_ready", block_ready_o, 1);
      chk("rst_valid", valid_o, 0);
      chk("rst_base", nonce_base_o, 0);
      chk("rst_lanes", lanes_o, 0);
      chk("rst_header", header_o, 0);
      chk("rst_done", done_o, 0);
      m_act = 0; m_done = 0; m_ab = 0; m_hdr = '0;
      @(negedge clk) rst = 0;
      done_seen = 0;
      repeat (3) cyc(0, '0, 0, 0);
      chk("rst_no_done", done_seen, 0);
      cyc(1, hD, 0, 0);
      chk("rst_restart_base", nonce_base_o, 0);
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 2) == 0, {8{$urandom}}, $urandom_range(0, 3) == 0,
             $urandom_range(0, 15) == 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
